// File: rtl/switch_port_requester.sv
// switch_port_requester: per-input-port initiator for the switch controller.
// Watches the head of the input buffer, requests a route reservation for the
// source-routed output port, streams the packet into the crossbar once granted
// and pulses a relieve after the last flit. All handshakes advance only while
// this instance's VC plane is active.
// Optional build macro: SWITCH_REQ_TIMEOUT_EN adds a grant timeout in REQ.
module switch_port_requester #(
  parameter int          DATA_WIDTH    = 16,
  parameter int          REQUEST_WIDTH = 2,
  parameter int          ROUTE_WIDTH   = 8,
  parameter int          VC            = 1,
  parameter int          AssignedVC    = 0,
  parameter int unsigned REQ_TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC:0]              VCPlaneSelector,
  input  logic [DATA_WIDTH-1:0]    in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     routeReserveRequestValid,
  output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic                     routeReserveStatus,
  output logic                     routeRelieve,
  output logic                     protocol_err,
  output logic                     req_timeout
);

  localparam logic [VC:0] ACTIVE_SEL = (VC+1)'(AssignedVC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    RELIEVE
  } state_t;

  state_t                   state_q, state_d;
  logic [REQUEST_WIDTH-1:0] port_q, port_d;
  logic                     perr_q, perr_d;

  logic                     vc_act;
  logic [1:0]               flit_type;
  logic                     is_head;
  logic                     is_last;
  logic [ROUTE_WIDTH-1:0]   route_shifted;
  logic [DATA_WIDTH-1:0]    head_out;

  assign vc_act    = (VCPlaneSelector == ACTIVE_SEL);
  assign flit_type = in_flit[DATA_WIDTH-1 -: 2];
  // Type encoding: bit 1 marks a head (head/single), bit 0 marks the packet's
  // last flit (tail/single).
  assign is_head   = flit_type[1];
  assign is_last   = flit_type[0];

  // Consume this hop: the next router sees the remaining route in the low bits.
  assign route_shifted = in_flit[ROUTE_WIDTH-1:0] >> REQUEST_WIDTH;
  assign head_out      = {in_flit[DATA_WIDTH-1:ROUTE_WIDTH], route_shifted};

`ifdef SWITCH_REQ_TIMEOUT_EN
  localparam int CNT_W = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // State, latched port and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= '0;
      perr_q  <= 1'b0;
`ifdef SWITCH_REQ_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      perr_q  <= perr_d;
`ifdef SWITCH_REQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Next-state logic; nothing moves while the plane is inactive
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    perr_d  = perr_q;
`ifdef SWITCH_REQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    if (vc_act) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_head) begin
              state_d = REQ;
              port_d  = in_flit[REQUEST_WIDTH-1:0];
`ifdef SWITCH_REQ_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end else begin
              perr_d = 1'b1;
            end
          end
        end
        REQ: begin
          if (routeReserveStatus) begin
            state_d = XFER;
          end
`ifdef SWITCH_REQ_TIMEOUT_EN
          else if (cnt_q == CNT_W'(REQ_TIMEOUT - 1)) begin
            // Give up; the head stays in the buffer and is re-requested from IDLE.
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
        XFER: begin
          if (in_valid && out_ready && is_last) begin
            state_d = RELIEVE;
          end
        end
        RELIEVE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: request held from REQ through RELIEVE, handshakes gated by plane
  always_comb begin
    in_ready                 = 1'b0;
    out_valid                = 1'b0;
    out_flit                 = '0;
    routeReserveRequestValid = (state_q != IDLE);
    routeReserveRequest      = (state_q != IDLE) ? port_q : '0;
    routeRelieve             = (state_q == RELIEVE);
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          in_ready = vc_act & in_valid & ~is_head;
        end
        XFER: begin
          out_valid = in_valid & vc_act;
          in_ready  = out_ready & vc_act;
          out_flit  = is_head ? head_out : in_flit;
        end
        default: begin
          in_ready  = 1'b0;
          out_valid = 1'b0;
        end
      endcase
    end
  end

  assign protocol_err = perr_q;

`ifdef SWITCH_REQ_TIMEOUT_EN
  assign req_timeout = tmo_q;
`else
  // No timeout logic in this build; the parameter is kept for a uniform interface.
  assign req_timeout = (REQ_TIMEOUT == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_switch_port_requester.sv
// Testbench for switch_port_requester: randomized and directed stimulus checked
// cycle by cycle against a packet-level reference model.
module tb_switch_port_requester;

  localparam logic [1:0] ACT_SEL = 2'd1;
`ifdef SWITCH_REQ_TIMEOUT_EN
  localparam bit TMO_BUILD = 1'b1;
`else
  localparam bit TMO_BUILD = 1'b0;
`endif
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [15:0] in_flit;
  logic        in_valid, in_ready;
  logic [15:0] out_flit;
  logic        out_valid, out_ready;
  logic        reqv;
  logic [1:0]  req;
  logic        grant, relieve, perr, rtmo;

  always #5 clk = ~clk;

  switch_port_requester #(
    .DATA_WIDTH   (16),
    .REQUEST_WIDTH(2),
    .ROUTE_WIDTH  (8),
    .VC           (1),
    .AssignedVC   (1),
    .REQ_TIMEOUT  (TMO)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .VCPlaneSelector         (sel),
    .in_flit                 (in_flit),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .out_flit                (out_flit),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .routeReserveRequestValid(reqv),
    .routeReserveRequest     (req),
    .routeReserveStatus      (grant),
    .routeRelieve            (relieve),
    .protocol_err            (perr),
    .req_timeout             (rtmo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] src[$];
  logic [15:0] exp_out[$];
  logic [15:0] got[$];

  // Packet-level reference model
  bit       m_busy, m_granted, m_relieve, m_perr, m_tmo;
  logic [1:0] m_port;
  int       m_cnt;

  // Stimulus knobs
  int vc_mode, valid_pct, ready_pct, grant_delay, stray_pct;
  int bp_at, bp_left, bp_violate;
  int cyc, req_wait;

  // Observations
  int relieve_cycles, first_relieve_cyc, last_tail_cyc;
  bit s_reqv, s_in_ready, s_rtmo;
  logic [1:0] s_req;

  function automatic bit f_head(input logic [15:0] f);
    return (f[15:14] == 2'b10) || (f[15:14] == 2'b11);
  endfunction

  function automatic bit f_last(input logic [15:0] f);
    return (f[15:14] == 2'b01) || (f[15:14] == 2'b11);
  endfunction

  function automatic logic [15:0] xform(input logic [15:0] f);
    if (f_head(f)) return (f & 16'hFF00) | ((f & 16'h00FF) >> 2);
    return f;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_granted = 0; m_relieve = 0; m_perr = 0; m_tmo = 0;
    m_port = '0; m_cnt = 0; req_wait = 0;
    src.delete(); exp_out.delete(); got.delete();
  endtask

  task automatic clear_stats();
    relieve_cycles = 0; first_relieve_cyc = -1; last_tail_cyc = -1;
    bp_at = -1; bp_left = 0; bp_violate = 0;
    got.delete(); exp_out.delete();
  endtask

  task automatic push_flit(input logic [15:0] f);
    src.push_back(f);
    exp_out.push_back(xform(f));
  endtask

  task automatic push_packet(input int len, input logic [15:0] head);
    if (len <= 1) begin
      push_flit({2'b11, head[13:0]});
    end else begin
      push_flit({2'b10, head[13:0]});
      for (int i = 0; i < len - 2; i++) push_flit({2'b00, 14'($urandom)});
      push_flit({2'b01, 14'($urandom)});
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic run_cycle();
    bit vc, v, r, g, idle, exp_ov, exp_iv;
    logic [15:0] f;
    logic [15:0] act[8];
    logic [15:0] expv[8];
    string       nm[8];
    int          nchk;
    case (vc_mode)
      0:       vc = 1'b1;
      1:       vc = (cyc % 2) == 0;
      default: vc = $urandom_range(0, 99) < 70;
    endcase
    sel = vc ? ACT_SEL : 2'((($urandom_range(0, 2)) + 2) % 4);
    v = (src.size() != 0) && ($urandom_range(0, 99) < valid_pct);
    f = (src.size() != 0) ? src[0] : 16'($urandom);
    r = $urandom_range(0, 99) < ready_pct;
    if (bp_left > 0 && got.size() == bp_at) begin
      r = 1'b0;
      bp_left--;
    end
    g = 1'b0;
    if (m_busy && !m_granted) begin
      if (req_wait >= grant_delay) g = 1'b1;
      req_wait++;
    end else begin
      req_wait = 0;
      g = $urandom_range(0, 99) < stray_pct;
    end
    in_valid = v; in_flit = f; out_ready = r; grant = g;
    #2;
    idle   = !m_busy;
    exp_ov = m_busy && m_granted && !m_relieve && vc && v;
    exp_iv = vc && ((idle && v && !f_head(f)) || (m_busy && m_granted && !m_relieve && r));
    nm[0] = "req_valid";    act[0] = 16'(reqv);      expv[0] = 16'(m_busy);
    nm[1] = "req_port";     act[1] = 16'(req);       expv[1] = m_busy ? 16'(m_port) : 16'h0;
    nm[2] = "relieve";      act[2] = 16'(relieve);   expv[2] = 16'(m_relieve);
    nm[3] = "out_valid";    act[3] = 16'(out_valid); expv[3] = 16'(exp_ov);
    nm[4] = "in_ready";     act[4] = 16'(in_ready);  expv[4] = 16'(exp_iv);
    nm[5] = "protocol_err"; act[5] = 16'(perr);      expv[5] = 16'(m_perr);
    nm[6] = "req_timeout";  act[6] = 16'(rtmo);      expv[6] = 16'(m_tmo);
    nm[7] = "out_flit";     act[7] = out_flit;       expv[7] = xform(f);
    nchk = exp_ov ? 8 : 7;
    for (int i = 0; i < nchk; i++) begin
      n_checks++;
      if (act[i] !== expv[i]) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %0h, expected %0h", nm[i], cyc, act[i], expv[i]);
      end
    end
    s_reqv = reqv; s_req = req; s_in_ready = in_ready; s_rtmo = rtmo;
    if (out_valid && out_ready) got.push_back(out_flit);
    if (relieve) begin
      relieve_cycles++;
      if (first_relieve_cyc < 0) first_relieve_cyc = cyc;
    end
    if (!r && in_ready && !idle) bp_violate++;
    if (vc) begin
      if (idle) begin
        if (v) begin
          if (f_head(f)) begin
            m_busy = 1; m_port = f[1:0]; m_cnt = 0;
          end else begin
            void'(src.pop_front());
            m_perr = 1;
          end
        end
      end else if (!m_granted) begin
        if (g) m_granted = 1;
        else if (TMO_BUILD) begin
          m_cnt++;
          if (m_cnt == TMO) begin m_busy = 0; m_tmo = 1; end
        end
      end else if (m_relieve) begin
        m_busy = 0; m_granted = 0; m_relieve = 0;
      end else if (v && r) begin
        void'(src.pop_front());
        if (f_last(f)) begin m_relieve = 1; last_tail_cyc = cyc; end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((src.size() != 0 || m_busy) && n < budget) begin
      run_cycle();
      n++;
    end
  endtask

  task automatic set_knobs(input int vm, input int vp, input int rp, input int gd, input int sp);
    vc_mode = vm; valid_pct = vp; ready_pct = rp; grant_delay = gd; stray_pct = sp;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = ACT_SEL; in_flit = 16'h8003; in_valid = 1'b1;
    out_ready = 1'b1; grant = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (reqv !== 1'b0)     begin n_fail++; $display("FAIL reset_reqv: got %0b, expected 0", reqv); end
    n_checks++; if (req !== 2'b00)     begin n_fail++; $display("FAIL reset_req: got %0h, expected 0", req); end
    n_checks++; if (relieve !== 1'b0)  begin n_fail++; $display("FAIL reset_relieve: got %0b, expected 0", relieve); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b, expected 0", in_ready); end
    n_checks++; if (out_flit !== 16'h0) begin n_fail++; $display("FAIL reset_out_flit: got %0h, expected 0", out_flit); end
    n_checks++; if (perr !== 1'b0)     begin n_fail++; $display("FAIL reset_protocol_err: got %0b, expected 0", perr); end
    n_checks++; if (rtmo !== 1'b0)     begin n_fail++; $display("FAIL reset_req_timeout: got %0b, expected 0", rtmo); end
    rst = 1'b0; in_valid = 1'b0; grant = 1'b0;
    model_clear();
  endtask

  task automatic test_single_packet();
    clear_stats();
    set_knobs(0, 100, 100, 3, 0);
    push_flit(16'h8007); push_flit(16'h1234); push_flit(16'h4321);
    run_until_idle(60);
    n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL sp_count: got %0d, expected 3", got.size()); end
    n_checks++; if (got.size() < 1 || got[0] !== 16'h8001) begin n_fail++; $display("FAIL sp_head: got %0h, expected 8001", (got.size() > 0) ? got[0] : 16'hx); end
    n_checks++; if (got.size() < 2 || got[1] !== 16'h1234) begin n_fail++; $display("FAIL sp_body: got %0h, expected 1234", (got.size() > 1) ? got[1] : 16'hx); end
    n_checks++; if (got.size() < 3 || got[2] !== 16'h4321) begin n_fail++; $display("FAIL sp_tail: got %0h, expected 4321", (got.size() > 2) ? got[2] : 16'hx); end
    n_checks++; if (relieve_cycles != 1) begin n_fail++; $display("FAIL sp_relieve_len: got %0d, expected 1", relieve_cycles); end
    n_checks++; if (first_relieve_cyc != last_tail_cyc + 1) begin n_fail++; $display("FAIL sp_relieve_at: got %0d, expected %0d", first_relieve_cyc, last_tail_cyc + 1); end
  endtask

  task automatic test_single_flit();
    clear_stats();
    set_knobs(0, 100, 100, 1, 0);
    push_flit(16'hC002);
    run_until_idle(40);
    n_checks++; if (got.size() != 1 || got[0] !== 16'hC000) begin n_fail++; $display("FAIL sf_flit: got %0h (n=%0d), expected C000", (got.size() > 0) ? got[0] : 16'hx, got.size()); end
    n_checks++; if (first_relieve_cyc != last_tail_cyc + 1) begin n_fail++; $display("FAIL sf_relieve_at: got %0d, expected %0d", first_relieve_cyc, last_tail_cyc + 1); end
    n_checks++; if (relieve_cycles != 1) begin n_fail++; $display("FAIL sf_relieve_len: got %0d, expected 1", relieve_cycles); end
  endtask

  task automatic test_vc_gating();
    clear_stats();
    set_knobs(1, 100, 100, 1, 0);
    push_packet(5, 16'h80F1);
    run_until_idle(80);
    n_checks++; if (got.size() != exp_out.size()) begin n_fail++; $display("FAIL vc_count: got %0d, expected %0d", got.size(), exp_out.size()); end
    foreach (exp_out[i]) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_out[i]) begin n_fail++; $display("FAIL vc_flit%0d: got %0h, expected %0h", i, (i < got.size()) ? got[i] : 16'hx, exp_out[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    set_knobs(0, 100, 100, 2, 0);
    push_packet(6, 16'h8046);
    bp_at = 2; bp_left = 5;
    run_until_idle(80);
    n_checks++; if (bp_left != 0) begin n_fail++; $display("FAIL bp_window: got %0d stall cycles left, expected 0", bp_left); end
    n_checks++; if (bp_violate != 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d, expected 0", bp_violate); end
    n_checks++; if (got.size() != exp_out.size()) begin n_fail++; $display("FAIL bp_count: got %0d, expected %0d", got.size(), exp_out.size()); end
    foreach (exp_out[i]) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_out[i]) begin n_fail++; $display("FAIL bp_flit%0d: got %0h, expected %0h", i, (i < got.size()) ? got[i] : 16'hx, exp_out[i]); end
    end
  endtask

  task automatic test_stray_body();
    clear_stats();
    set_knobs(0, 100, 100, 1, 0);
    src.push_back(16'h0055);
    run_cycle();
    n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL stray_consumed: got %0b, expected 1", s_in_ready); end
    n_checks++; if (s_reqv !== 1'b0) begin n_fail++; $display("FAIL stray_no_req: got %0b, expected 0", s_reqv); end
    repeat (3) run_cycle();
    n_checks++; if (perr !== 1'b1) begin n_fail++; $display("FAIL stray_perr: got %0b, expected 1", perr); end
    n_checks++; if (reqv !== 1'b0) begin n_fail++; $display("FAIL stray_idle_req: got %0b, expected 0", reqv); end
    push_packet(2, 16'h8011);
    run_until_idle(40);
    n_checks++; if (perr !== 1'b1) begin n_fail++; $display("FAIL stray_perr_sticky: got %0b, expected 1", perr); end
  endtask

  task automatic test_timeout();
    int rise1, drop, rise2, port2;
    bit prev;
    clear_stats();
    set_knobs(0, 100, 100, 1000, 0);
    push_flit(16'h8006); push_flit(16'h4ABC);
    rise1 = -1; drop = -1; rise2 = -1; port2 = -1; prev = 1'b0;
    for (int i = 0; i < 40 && rise2 < 0; i++) begin
      run_cycle();
      if (s_reqv && !prev) begin
        if (rise1 < 0) rise1 = i;
        else begin rise2 = i; port2 = int'(s_req); end
      end
      if (!s_reqv && prev && drop < 0) drop = i;
      prev = s_reqv;
    end
    if (TMO_BUILD) begin
      n_checks++; if (drop - rise1 != TMO) begin n_fail++; $display("FAIL tmo_req_len: got %0d, expected %0d", drop - rise1, TMO); end
      n_checks++; if (rise2 - drop != 1) begin n_fail++; $display("FAIL tmo_gap: got %0d, expected 1", rise2 - drop); end
      n_checks++; if (port2 != 2) begin n_fail++; $display("FAIL tmo_port: got %0d, expected 2", port2); end
      n_checks++; if (rtmo !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %0b, expected 1", rtmo); end
    end else begin
      n_checks++; if (drop != -1) begin n_fail++; $display("FAIL notmo_drop: got %0d, expected -1", drop); end
      n_checks++; if (rtmo !== 1'b0) begin n_fail++; $display("FAIL notmo_flag: got %0b, expected 0", rtmo); end
    end
    grant_delay = 2;
    run_until_idle(60);
    n_checks++; if (got.size() != 2 || got[0] !== 16'h8001) begin n_fail++; $display("FAIL tmo_flits: got %0h (n=%0d), expected 8001", (got.size() > 0) ? got[0] : 16'hx, got.size()); end
  endtask

  task automatic test_random();
    clear_stats();
    set_knobs(2, 70, 70, 2, 20);
    for (int p = 0; p < 25; p++) push_packet($urandom_range(1, 5), 16'($urandom));
    run_until_idle(4000);
    n_checks++; if (got.size() != exp_out.size()) begin n_fail++; $display("FAIL rnd_count: got %0d, expected %0d", got.size(), exp_out.size()); end
    foreach (exp_out[i]) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp_out[i]) begin n_fail++; $display("FAIL rnd_flit%0d: got %0h, expected %0h", i, (i < got.size()) ? got[i] : 16'hx, exp_out[i]); end
    end
  endtask

  task automatic test_reset_midpacket();
    int n;
    clear_stats();
    set_knobs(0, 100, 100, 1, 0);
    push_packet(4, 16'h8023);
    n = 0;
    while (got.size() < 1 && n < 50) begin run_cycle(); n++; end
    n_checks++; if (got.size() != 1) begin n_fail++; $display("FAIL rmp_started: got %0d flits, expected 1", got.size()); end
    rst = 1'b1; in_valid = 1'b0; grant = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (reqv !== 1'b0)     begin n_fail++; $display("FAIL rmp_reqv: got %0b, expected 0", reqv); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_out_valid: got %0b, expected 0", out_valid); end
    n_checks++; if (perr !== 1'b0)     begin n_fail++; $display("FAIL rmp_perr: got %0b, expected 0", perr); end
    rst = 1'b0;
    model_clear();
    clear_stats();
    push_packet(3, 16'h8082);
    run_until_idle(60);
    n_checks++; if (got.size() != 3 || got[0] !== 16'h8020) begin n_fail++; $display("FAIL rmp_recover: got %0h (n=%0d), expected 8020", (got.size() > 0) ? got[0] : 16'hx, got.size()); end
  endtask

  initial begin
    cyc = 0;
    set_knobs(0, 100, 100, 1, 0);
    clear_stats();
    test_reset();
    test_single_packet();
    test_single_flit();
    test_vc_gating();
    test_backpressure();
    test_stray_body();
    test_timeout();
    test_random();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_port_requester.md
# switch_port_requester

Per-input-port initiator for the switch controller: it watches the head of its input buffer, decodes the source-routed output port and holds a route reservation request until it is granted. It then streams the packet's flits into the crossbar and pulses a relieve after the tail flit. One instance sits between each input buffer and the switch controller, per VC plane. All handshakes advance only while that plane is active.

## Interface
- `DATA_WIDTH`, default 16: flit width; the top 2 bits are the flit type.
- `REQUEST_WIDTH`, default 2: output-port index width (4 outputs).
- `ROUTE_WIDTH`, default 8: source-route field in the low bits of a head flit (4 hops × 2 bits).
- `VC`, default 1: `VCPlaneSelector` is VC+1 bits wide.
- `AssignedVC`, default 0: plane on which this instance is active.
- `REQ_TIMEOUT`, default 64: active cycles to wait for a grant (timeout build only).
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `VCPlaneSelector`, in, VC+1: currently active plane. `vc_act` = (VCPlaneSelector == AssignedVC).
- `in_flit`, in, DATA_WIDTH: flit at the head of the input buffer.
- `in_valid`, in, 1: `in_flit` valid.
- `in_ready`, out, 1: flit consumed at this edge when high with `in_valid`.
- `out_flit`, out, DATA_WIDTH: flit to the crossbar.
- `out_valid`, out, 1: `out_flit` valid.
- `out_ready`, in, 1: downstream accepts.
- `routeReserveRequestValid`, out, 1: reservation request.
- `routeReserveRequest`, out, REQUEST_WIDTH: requested output port.
- `routeReserveStatus`, in, 1: one-cycle grant pulse from the controller.
- `routeRelieve`, out, 1: release the reserved path.
- `protocol_err`, out, 1: sticky; a body or tail flit arrived while IDLE.
- `req_timeout`, out, 1: sticky grant-timeout flag.

## Operation
- Flit types: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail).
- FSM with 4 states, IDLE, REQ, XFER, RELIEVE. Transitions happen only on edges where `vc_act`=1.
- **IDLE**
  - `in_valid` and head/single: latch `port` = in_flit[REQUEST_WIDTH-1:0] and go to REQ. The flit is not consumed.
  - `in_valid` and body/tail: consume it (`in_ready`=1), discard it, set `protocol_err`.
- **REQ**
  - `routeReserveRequestValid`=1 and `routeReserveRequest`=`port`.
  - `routeReserveStatus`=1 at an active edge: go to XFER.
- **XFER**
  - `out_valid` = in_valid & vc_act; `in_ready` = out_ready & vc_act.
  - Head/single flits go out with the low ROUTE_WIDTH bits logically shifted right by REQUEST_WIDTH, zero-filled. All other bits pass unchanged.
  - Body/tail flits pass unmodified.
  - A tail or single handshake moves the FSM to RELIEVE.
- **RELIEVE**
  - `routeRelieve`=1.
  - Leave for IDLE on the first active edge.
- Request hold: `routeReserveRequestValid` and `routeReserveRequest` stay asserted and stable from REQ entry through the RELIEVE exit edge, because the controller uses the request during the whole reservation. They drop to 0 in IDLE.
- Inactive plane (`vc_act`=0): state, counters and flags hold; `in_ready`=0 and `out_valid`=0; the request and relieve outputs hold their levels.
- A grant pulse outside REQ is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, sticky flags cleared.
- Best case with `vc_act` constantly 1:
  - head visible at edge 0: REQ from edge 1, request high in cycle 1;
  - grant at edge g: `out_valid` may rise in cycle g+1;
  - one flit per cycle while `out_ready`=1;
  - tail handshake at edge t: `routeRelieve` high in cycle t+1, IDLE after edge t+2.
- Back-to-back packets: the next head is latched no earlier than the IDLE cycle, so there is a minimum of 1 idle cycle between relieve and the next request.
- Reset mid-packet: immediate return to IDLE with all outputs 0. Upstream and controller are reset together.

## Configuration
- `SWITCH_REQ_TIMEOUT_EN` defined:
  - a counter of active cycles spent in REQ;
  - on reaching REQ_TIMEOUT without a grant: set `req_timeout`, go to IDLE (request drops for at least 1 cycle), then re-request;
  - the counter clears on REQ entry.
- Not defined: REQ waits indefinitely; `req_timeout` is tied to 0.

## Test plan
- **Single packet**: head 16'h8007 (port 3, route 8'h07), body, tail; grant 3 cycles after request.
  - Request = 3 held until relieve.
  - Output head = 16'h8001, then body and tail unchanged.
  - `routeRelieve` is one cycle, the cycle after the tail handshake.
- **Single flit**: 16'hC002 (port 2).
  - Output = 16'hC000, immediately followed by relieve.
- **VC gating**: `VCPlaneSelector` alternates between AssignedVC and another plane during XFER.
  - No flit moves on inactive cycles.
  - The flit count equals the count sent.
  - A relieve asserted on an inactive cycle stays high until the next active edge.
- **Backpressure**: `out_ready` low for 5 cycles mid-packet.
  - `in_ready` stays low.
  - No flit is duplicated or lost.
- **Stray body in IDLE**: 16'h0055 presented while IDLE.
  - Consumed in 1 cycle.
  - `protocol_err`=1 and stays set.
  - No request is raised.
- **Timeout build**: REQ_TIMEOUT=8 with no grant.
  - `req_timeout` sets after 8 active cycles.
  - Request drops for 1 cycle, then re-asserts with the same port.
